// File: rtl/game_start_controller.sv
// Start-switch front end and game sequencer: synchronise/debounce the raw switch,
// run a seconds countdown, then enable and time the game until it ends or is aborted.
module game_start_controller #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TICK_CYCLES     = 100_000_000,
    parameter int COUNTDOWN_SEC   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        startswt,
    input  logic        game_over,
    output logic        start_db,
    output logic [1:0]  state,
    output logic [3:0]  countdown,
    output logic        start_pulse,
    output logic        run_en,
    output logic [15:0] game_time
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW  = $clog2(TICK_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNTDOWN = 2'd1,
        RUN       = 2'd2,
        OVER      = 2'd3
    } state_t;

    state_t          cur;
    logic            sync1;
    logic            sync2;
    logic [DBW-1:0]  db_cnt;
    logic            start_db_q;
    logic [TW-1:0]   tick_cnt;
    logic            db_rise;
    logic            tick;

    assign state   = cur;
    assign db_rise = start_db & ~start_db_q;
    assign tick    = (tick_cnt == TW'(TICK_CYCLES - 1));

    // The switch is asynchronous to clk, so it passes two flops before anything looks at it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= startswt;
            sync2 <= sync1;
        end
    end

    // start_db only follows the synchronised level after it has disagreed for a full window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_db <= 1'b0;
            db_cnt   <= '0;
        end else if (sync2 == start_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
            start_db <= ~start_db;
            db_cnt   <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // A falling debounced switch always wins; the tick counter restarts on every state entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur         <= IDLE;
            countdown   <= 4'd0;
            start_pulse <= 1'b0;
            run_en      <= 1'b0;
            game_time   <= 16'd0;
            tick_cnt    <= '0;
            start_db_q  <= 1'b0;
        end else begin
            start_pulse <= 1'b0;
            start_db_q  <= start_db;
            case (cur)
                IDLE: begin
                    if (db_rise) begin
                        cur       <= COUNTDOWN;
                        countdown <= 4'(COUNTDOWN_SEC);
                        tick_cnt  <= '0;
                    end
                end
                COUNTDOWN: begin
                    if (!start_db) begin
                        cur       <= IDLE;
                        countdown <= 4'd0;
                        tick_cnt  <= '0;
                    end else if (tick) begin
                        tick_cnt <= '0;
                        if (countdown > 4'd1) begin
                            countdown <= countdown - 4'd1;
                        end else begin
                            cur         <= RUN;
                            countdown   <= 4'd0;
                            start_pulse <= 1'b1;
                            run_en      <= 1'b1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!start_db) begin
                        cur       <= IDLE;
                        run_en    <= 1'b0;
                        game_time <= 16'd0;
                        tick_cnt  <= '0;
                    end else begin
                        if (tick) begin
                            tick_cnt <= '0;
                            if (game_time != 16'hFFFF) begin
                                game_time <= game_time + 16'd1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                        if (game_over) begin
                            cur      <= OVER;
                            run_en   <= 1'b0;
                            tick_cnt <= '0;
                        end
                    end
                end
                OVER: begin
                    if (!start_db) begin
                        cur       <= IDLE;
                        game_time <= 16'd0;
                    end
                end
                default: cur <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_start_controller.sv
// Randomised bench for game_start_controller, checked against a cycle-indexed
// behavioural model built from the switch history and elapsed-time arithmetic.
module tb_game_start_controller;

    localparam int DB    = 4;
    localparam int TICKS = 10;
    localparam int CDSEC = 3;

    logic        clk;
    logic        rst_n;
    logic        startswt;
    logic        game_over;
    logic        start_db;
    logic [1:0]  state;
    logic [3:0]  countdown;
    logic        start_pulse;
    logic        run_en;
    logic [15:0] game_time;
    logic [24:0] act_vec;

    int checks;
    int errors;

    int cyc;
    bit hist[$];
    int mis_run;
    bit m_db;
    bit m_db_prev;
    int m_state;
    int m_entry;
    int m_cd;
    int m_time;
    bit m_pulse;

    game_start_controller #(
        .DEBOUNCE_CYCLES(DB),
        .TICK_CYCLES(TICKS),
        .COUNTDOWN_SEC(CDSEC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .startswt(startswt),
        .game_over(game_over),
        .start_db(start_db),
        .state(state),
        .countdown(countdown),
        .start_pulse(start_pulse),
        .run_en(run_en),
        .game_time(game_time)
    );

    assign act_vec = {start_db, state, countdown, start_pulse, run_en, game_time};

    always #5 clk = ~clk;

    function automatic logic [24:0] exp_vec();
        return {m_db, 2'(m_state), 4'(m_cd), m_pulse, logic'(m_state == 2), 16'(m_time)};
    endfunction

    task automatic model_reset();
        hist.delete();
        mis_run   = 0;
        m_db      = 0;
        m_db_prev = 0;
        m_state   = 0;
        m_entry   = 0;
        m_cd      = 0;
        m_time    = 0;
        m_pulse   = 0;
    endtask

    // Seconds are whole multiples of TICKS edges after the edge that entered the state.
    task automatic model_edge(input bit sw, input bit go);
        bit tick;
        bit delayed;
        cyc++;
        tick = (m_state == 1 || m_state == 2) && ((cyc - m_entry) % TICKS == 0);
        m_pulse = 0;
        case (m_state)
            0: if (m_db && !m_db_prev) begin
                   m_state = 1; m_cd = CDSEC; m_entry = cyc;
               end
            1: if (!m_db) begin
                   m_state = 0; m_cd = 0;
               end else if (tick) begin
                   if (m_cd > 1) m_cd--;
                   else begin
                       m_state = 2; m_cd = 0; m_pulse = 1; m_entry = cyc;
                   end
               end
            2: if (!m_db) begin
                   m_state = 0; m_time = 0;
               end else begin
                   if (tick && m_time < 65535) m_time++;
                   if (go) m_state = 3;
               end
            default: if (!m_db) begin
                   m_state = 0; m_time = 0;
               end
        endcase
        delayed = (hist.size() >= 2) ? hist[hist.size() - 2] : 1'b0;
        hist.push_back(sw);
        if (hist.size() > 8) void'(hist.pop_front());
        m_db_prev = m_db;
        if (delayed != m_db) begin
            mis_run++;
            if (mis_run == DB) begin
                m_db = !m_db;
                mis_run = 0;
            end
        end else begin
            mis_run = 0;
        end
    endtask

    task automatic applyStimulus(input bit sw, input bit go);
        startswt  = sw;
        game_over = go;
        @(posedge clk);
        model_edge(sw, go);
        @(negedge clk);
        game_over = 1'b0;
    endtask

    task automatic go_to_run();
        for (int i = 0; i < 80 && m_state != 2; i++) applyStimulus(1'b1, 1'b0);
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (act_vec !== 25'd0) begin
            errors++;
            $display("[TB] FAIL async_reset actual=%h expected=%h", act_vec, 25'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0);
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL post_reset cyc=%0d actual=%h expected=%h", cyc, act_vec, exp_vec());
            end
        end
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_state actual=%0d expected=0", state);
        end
    endtask

    task automatic test_glitch();
        int gap;
        for (int len = 1; len <= 3; len++) begin
            for (int i = 0; i < len; i++) begin
                applyStimulus(1'b1, 1'b0);
                checks++;
                if (act_vec !== exp_vec()) begin
                    errors++;
                    $display("[TB] FAIL glitch cyc=%0d actual=%h expected=%h", cyc, act_vec, exp_vec());
                end
            end
            gap = $urandom_range(4, 9);
            for (int i = 0; i < gap; i++) begin
                applyStimulus(1'b0, 1'($urandom_range(0, 1)));
                checks++;
                if (act_vec !== exp_vec()) begin
                    errors++;
                    $display("[TB] FAIL glitch_gap cyc=%0d actual=%h expected=%h", cyc, act_vec, exp_vec());
                end
            end
            checks++;
            if (start_db !== 1'b0 || state !== 2'd0) begin
                errors++;
                $display("[TB] FAIL glitch_len%0d actual db=%b state=%0d expected db=0 state=0", len, start_db, state);
            end
        end
    endtask

    task automatic test_countdown();
        for (int n = 1; n <= 87; n++) begin
            applyStimulus(1'b1, 1'b0);
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL countdown_seq n=%0d actual=%h expected=%h", n, act_vec, exp_vec());
            end
            if (n == 5 || n == 6 || n == 7 || n == 17 || n == 27 || n == 37 || n == 38 || n == 87) begin
                logic [24:0] want;
                case (n)
                    5:       want = {1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 16'd0};
                    6:       want = {1'b1, 2'd0, 4'd0, 1'b0, 1'b0, 16'd0};
                    7:       want = {1'b1, 2'd1, 4'd3, 1'b0, 1'b0, 16'd0};
                    17:      want = {1'b1, 2'd1, 4'd2, 1'b0, 1'b0, 16'd0};
                    27:      want = {1'b1, 2'd1, 4'd1, 1'b0, 1'b0, 16'd0};
                    37:      want = {1'b1, 2'd2, 4'd0, 1'b1, 1'b1, 16'd0};
                    38:      want = {1'b1, 2'd2, 4'd0, 1'b0, 1'b1, 16'd0};
                    default: want = {1'b1, 2'd2, 4'd0, 1'b0, 1'b1, 16'd5};
                endcase
                checks++;
                if (act_vec !== want) begin
                    errors++;
                    $display("[TB] FAIL countdown_at_%0d actual=%h expected=%h", n, act_vec, want);
                end
            end
        end
    endtask

    task automatic test_game_over();
        int w;
        w = $urandom_range(0, 8);
        for (int i = 0; i < w; i++) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b1, 1'($urandom_range(0, 1)));
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL over_hold cyc=%0d actual=%h expected=%h", cyc, act_vec, exp_vec());
            end
        end
        checks++;
        if (state !== 2'd3 || run_en !== 1'b0 || game_time !== 16'd5) begin
            errors++;
            $display("[TB] FAIL over_state actual st=%0d en=%b t=%0d expected st=3 en=0 t=5", state, run_en, game_time);
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0);
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL over_exit cyc=%0d actual=%h expected=%h", cyc, act_vec, exp_vec());
            end
        end
        checks++;
        if (state !== 2'd0 || game_time !== 16'd0) begin
            errors++;
            $display("[TB] FAIL over_to_idle actual st=%0d t=%0d expected st=0 t=0", state, game_time);
        end
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0);
        checks++;
        if (state !== 2'd1 || countdown !== 4'd3) begin
            errors++;
            $display("[TB] FAIL restart actual st=%0d cd=%0d expected st=1 cd=3", state, countdown);
        end
    endtask

    task automatic test_abort();
        bit pulse_seen;
        pulse_seen = 0;
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0);
        checks++;
        if (countdown !== 4'd2) begin
            errors++;
            $display("[TB] FAIL abort_pre actual cd=%0d expected cd=2", countdown);
        end
        for (int n = 1; n <= 12; n++) begin
            applyStimulus(1'b0, 1'b0);
            pulse_seen |= start_pulse;
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL abort_seq n=%0d actual=%h expected=%h", n, act_vec, exp_vec());
            end
            if (n == 6 || n == 7) begin
                checks++;
                if (state !== ((n == 6) ? 2'd1 : 2'd0)) begin
                    errors++;
                    $display("[TB] FAIL abort_at_%0d actual st=%0d expected st=%0d", n, state, (n == 6) ? 1 : 0);
                end
            end
        end
        checks++;
        if (state !== 2'd0 || countdown !== 4'd0 || pulse_seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_end actual st=%0d cd=%0d pulse=%b expected st=0 cd=0 pulse=0", state, countdown, pulse_seen);
        end
    endtask

    task automatic test_simultaneous();
        int w;
        bit go;
        go_to_run();
        checks++;
        if (state !== 2'd2) begin
            errors++;
            $display("[TB] FAIL sim_reach_run actual st=%0d expected st=2", state);
        end
        w = $urandom_range(0, 15);
        for (int i = 0; i < w; i++) applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            go = (m_db == 0 && m_state == 2);
            applyStimulus(1'b0, go);
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL sim_seq cyc=%0d actual=%h expected=%h", cyc, act_vec, exp_vec());
            end
        end
        checks++;
        if (state !== 2'd0 || game_time !== 16'd0) begin
            errors++;
            $display("[TB] FAIL sim_abort actual st=%0d t=%0d expected st=0 t=0", state, game_time);
        end
    endtask

    task automatic test_tick_game_over();
        go_to_run();
        for (int i = 0; i < TICKS && (cyc + 1 - m_entry) % TICKS != 0; i++) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checks++;
        if (state !== 2'd3 || game_time !== 16'd1) begin
            errors++;
            $display("[TB] FAIL tick_and_over actual st=%0d t=%0d expected st=3 t=1", state, game_time);
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0);
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL tick_over_exit cyc=%0d actual=%h expected=%h", cyc, act_vec, exp_vec());
            end
        end
    endtask

    task automatic test_saturation();
        go_to_run();
        force dut.game_time = 16'hFFFE;
        #1;
        release dut.game_time;
        m_time = 16'hFFFE;
        for (int n = 1; n <= 30; n++) begin
            applyStimulus(1'b1, 1'b0);
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL sat_seq n=%0d actual=%h expected=%h", n, act_vec, exp_vec());
            end
            if (n == 9 || n == 10) begin
                checks++;
                if (game_time !== ((n == 9) ? 16'hFFFE : 16'hFFFF)) begin
                    errors++;
                    $display("[TB] FAIL sat_at_%0d actual=%h expected=%h", n, game_time, (n == 9) ? 16'hFFFE : 16'hFFFF);
                end
            end
        end
        checks++;
        if (game_time !== 16'hFFFF || state !== 2'd2) begin
            errors++;
            $display("[TB] FAIL sat_hold actual t=%h st=%0d expected t=ffff st=2", game_time, state);
        end
    endtask

    task automatic test_back_to_back();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (act_vec !== 25'd0) begin
            errors++;
            $display("[TB] FAIL midrun_reset actual=%h expected=%h", act_vec, 25'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int n = 1; n <= 8; n++) begin
            applyStimulus(1'b1, 1'b0);
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL held_through_reset n=%0d actual=%h expected=%h", n, act_vec, exp_vec());
            end
        end
        checks++;
        if (state !== 2'd1 || countdown !== 4'd3) begin
            errors++;
            $display("[TB] FAIL rearm_after_reset actual st=%0d cd=%0d expected st=1 cd=3", state, countdown);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b1;
        startswt  = 1'b0;
        game_over = 1'b0;
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        model_reset();
        test_reset();
        test_glitch();
        test_countdown();
        test_game_over();
        test_abort();
        test_simultaneous();
        test_tick_game_over();
        test_saturation();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
